byte_pack_fifo_hs: RTL and testbench

//  Byte-granular packing FIFO: accepts 1..IN_BYTES valid bytes per beat and emits a requested byte count per beat.

---
 rtl/byte_pack_fifo_hs_pkg.sv | 14 +
 rtl/byte_pack_fifo_hs_if.sv | 30 +++
 rtl/byte_pack_fifo_hs_shifter.sv | 20 ++
 rtl/byte_pack_fifo_hs.sv | 140 ++++++++++++++
 tb/tb_byte_pack_fifo_hs.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/byte_pack_fifo_hs_pkg.sv
// Shared types and helpers for the byte packing FIFO.
package byte_pack_fifo_hs_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Byte lane survives a mask of nbytes valid bytes counted from lane 0.
    function automatic bit lane_kept(input int unsigned lane, input int unsigned nbytes);
        return lane < nbytes;
    endfunction

endpackage

// File: rtl/byte_pack_fifo_hs_if.sv
// Input/output beat handshake bundle of the byte packing FIFO.
interface byte_pack_fifo_hs_if #(
    parameter int IN_BYTES  = 16,
    parameter int OUT_BYTES = 16
);
    localparam int IN_W  = $clog2(IN_BYTES + 1);
    localparam int OUT_W = $clog2(OUT_BYTES + 1);

    logic                   in_valid;
    logic                   in_ready;
    logic [IN_BYTES*8-1:0]  in_data;
    logic [IN_W-1:0]        in_nbytes;

    logic [OUT_W-1:0]       out_req;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_BYTES*8-1:0] out_data;
    logic [OUT_W-1:0]       out_nbytes;

    modport slave (
        input  in_valid, in_data, in_nbytes, out_req, out_ready,
        output in_ready, out_valid, out_data, out_nbytes
    );

    modport master (
        output in_valid, in_data, in_nbytes, out_req, out_ready,
        input  in_ready, out_valid, out_data, out_nbytes
    );

endinterface

// File: rtl/byte_pack_fifo_hs_shifter.sv
// Byte-lane barrel shifter: shifts a byte vector left or right by a byte count, zero fill.
module byte_pack_fifo_hs_shifter #(
    parameter int NBYTES     = 32,
    parameter int SH_W       = 6,
    parameter bit SHIFT_LEFT = 1'b0
) (
    input  logic [NBYTES*8-1:0] data_i,
    input  logic [SH_W-1:0]     sh_i,
    output logic [NBYTES*8-1:0] data_o
);
    logic [SH_W+2:0] sh_bits;
    assign sh_bits = {sh_i, 3'b000};

    if (SHIFT_LEFT) begin : g_left
        assign data_o = data_i << sh_bits;
    end else begin : g_right
        assign data_o = data_i >> sh_bits;
    end

endmodule

// File: rtl/byte_pack_fifo_hs.sv
// Byte-granular packing FIFO with valid/ready on both sides, drain mode and length-error flag.
module byte_pack_fifo_hs
    import byte_pack_fifo_hs_pkg::*;
#(
    parameter  int IN_BYTES   = 16,
    parameter  int OUT_BYTES  = 16,
    parameter  int FIFO_BYTES = 32,
    localparam int IN_W       = $clog2(IN_BYTES + 1),
    localparam int OUT_W      = $clog2(OUT_BYTES + 1),
    localparam int LVL_W      = $clog2(FIFO_BYTES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync_rst_i,
    input  logic                drain_i,
    byte_pack_fifo_hs_if.slave  bus,
    output logic [LVL_W-1:0]    level_o,
    output logic                draining_o,
    output logic                err_len_o
);
    localparam int FB8 = FIFO_BYTES * 8;

    if (FIFO_BYTES < IN_BYTES + OUT_BYTES - 1) begin : g_depth_chk
        $error("byte_pack_fifo_hs: FIFO_BYTES must be >= IN_BYTES+OUT_BYTES-1");
    end

    state_e             state_q, state_d;
    logic [LVL_W-1:0]   level_q, level_d, lvl_nxt;
    logic [FB8-1:0]     stor_q, stor_d;
    logic               err_q, err_d;

    logic               in_len_ok, req_ok, would_valid;
    logic               in_ready, out_valid, push, pop;
    logic [OUT_W-1:0]   out_n, out_nbytes;
    logic [LVL_W-1:0]   req_l, push_n, pop_n, ins_off;
    logic [FB8-1:0]     ins_raw, head_sh, ins_sh;

    assign in_len_ok = (bus.in_nbytes != '0) && (bus.in_nbytes <= IN_W'(IN_BYTES));
    assign req_ok    = (bus.out_req != '0) && (bus.out_req <= OUT_W'(OUT_BYTES));
    assign req_l     = LVL_W'(bus.out_req);

    // FSM output process: handshake and beat size from registered state only.
    always_comb begin
        in_ready    = 1'b0;
        would_valid = 1'b0;
        out_n       = '0;
        case (state_q)
            ST_FILL: begin
                in_ready    = level_q <= LVL_W'(FIFO_BYTES - IN_BYTES);
                would_valid = level_q >= req_l;
                out_n       = bus.out_req;
            end
            ST_DRAIN: begin
                would_valid = level_q != '0;
                out_n       = (level_q < req_l) ? OUT_W'(level_q) : bus.out_req;
            end
            default: ;
        endcase
    end

    // Out-of-range out_req suppresses the beat rather than emitting a bogus size.
    assign out_valid  = would_valid & req_ok;
    assign out_nbytes = out_valid ? out_n : '0;
    assign push       = bus.in_valid & in_ready & in_len_ok;
    assign pop        = out_valid & bus.out_ready;
    assign push_n     = push ? LVL_W'(bus.in_nbytes) : '0;
    assign pop_n      = pop ? LVL_W'(out_n) : '0;
    assign ins_off    = level_q - pop_n;
    assign lvl_nxt    = level_q - pop_n + push_n;

    for (genvar b = 0; b < FIFO_BYTES; b++) begin : g_ins
        if (b < IN_BYTES) begin : g_lane
            assign ins_raw[b*8 +: 8] = lane_kept(b, 32'(push_n)) ? bus.in_data[b*8 +: 8] : 8'h00;
        end else begin : g_pad
            assign ins_raw[b*8 +: 8] = 8'h00;
        end
    end

    byte_pack_fifo_hs_shifter #(.NBYTES(FIFO_BYTES), .SH_W(LVL_W), .SHIFT_LEFT(1'b0)) u_pop_sh (
        .data_i (stor_q),
        .sh_i   (pop_n),
        .data_o (head_sh)
    );

    byte_pack_fifo_hs_shifter #(.NBYTES(FIFO_BYTES), .SH_W(LVL_W), .SHIFT_LEFT(1'b1)) u_ins_sh (
        .data_i (ins_raw),
        .sh_i   (ins_off),
        .data_o (ins_sh)
    );

    // Bytes above level are always zero, so the insert can simply be OR-ed in.
    assign stor_d  = sync_rst_i ? '0 : (head_sh | ins_sh);
    assign level_d = sync_rst_i ? '0 : lvl_nxt;
    assign err_d   = sync_rst_i ? 1'b0
                   : err_q | (bus.in_valid & in_ready & ~in_len_ok) | (would_valid & ~req_ok);

    // FSM next-state process.
    always_comb begin
        state_d = state_q;
        if (sync_rst_i) begin
            state_d = ST_FILL;
        end else begin
            case (state_q)
                ST_FILL:  if (drain_i && lvl_nxt != '0) state_d = ST_DRAIN;
                ST_DRAIN: if (lvl_nxt == '0)            state_d = ST_FILL;
                default:                                state_d = ST_FILL;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_FILL;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            stor_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            stor_q  <= stor_d;
            err_q   <= err_d;
        end
    end

    for (genvar b = 0; b < OUT_BYTES; b++) begin : g_out
        assign bus.out_data[b*8 +: 8] = lane_kept(b, 32'(out_nbytes)) ? stor_q[b*8 +: 8] : 8'h00;
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_nbytes = out_nbytes;
    assign level_o        = level_q;
    assign draining_o     = (state_q == ST_DRAIN);
    assign err_len_o      = err_q;

endmodule

// File: tb/tb_byte_pack_fifo_hs.sv
// Bench for byte_pack_fifo_hs: directed vector table, reset sequence, then random traffic vs a byte-queue model.
module tb_byte_pack_fifo_hs;
    localparam int IB = 16;
    localparam int OB = 16;
    localparam int FB = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       srst = 1'b0;
    logic       drain = 1'b0;
    logic [5:0] level;
    logic       draining, err_len;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    byte_pack_fifo_hs_if #(.IN_BYTES(IB), .OUT_BYTES(OB)) bus ();

    byte_pack_fifo_hs #(.IN_BYTES(IB), .OUT_BYTES(OB), .FIFO_BYTES(FB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_rst_i (srst),
        .drain_i    (drain),
        .bus        (bus),
        .level_o    (level),
        .draining_o (draining),
        .err_len_o  (err_len)
    );

    typedef struct {
        logic         iv;
        int           nb;
        logic [7:0]   base;
        logic         dr;
        int           req;
        logic         ordy;
        logic         sr;
        logic         e_rdy;
        logic         e_ov;
        int           e_n;
        int           e_lvl;
        logic [127:0] e_data;
        logic         e_drn;
        logic         e_err;
    } vec_t;

    vec_t tbl[$];

    logic [7:0] mq[$];
    bit         m_drn;
    bit         m_err;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mkdata(input logic [7:0] base);
        logic [127:0] d;
        for (int k = 0; k < IB; k++) d[k*8 +: 8] = base + 8'(k);
        return d;
    endfunction

    task automatic drive(input logic iv, input int nb, input logic [127:0] d, input logic dr,
                         input int req, input logic ordy, input logic sr);
        bus.in_valid  = iv;
        bus.in_nbytes = 5'(nb);
        bus.in_data   = d;
        drain         = dr;
        bus.out_req   = 5'(req);
        bus.out_ready = ordy;
        srst          = sr;
    endtask

    task automatic add(input logic iv, input int nb, input logic [7:0] base, input logic dr,
                       input int req, input logic ordy, input logic sr,
                       input logic rdy, input logic ov, input int n, input int lvl,
                       input logic [127:0] data, input logic drn, input logic err);
        vec_t v;
        v.iv = iv; v.nb = nb; v.base = base; v.dr = dr; v.req = req; v.ordy = ordy; v.sr = sr;
        v.e_rdy = rdy; v.e_ov = ov; v.e_n = n; v.e_lvl = lvl; v.e_data = data;
        v.e_drn = drn; v.e_err = err;
        tbl.push_back(v);
    endtask

    task automatic chk_all(input logic rdy, input logic ov, input int n, input int lvl,
                           input logic [127:0] data, input logic drn, input logic err);
        chk("in_ready",   128'(bus.in_ready),   128'(rdy));
        chk("out_valid",  128'(bus.out_valid),  128'(ov));
        chk("out_nbytes", 128'(bus.out_nbytes), 128'(n));
        chk("out_data",   bus.out_data,         data);
        chk("level",      128'(level),          128'(lvl));
        chk("draining",   128'(draining),       128'(drn));
        chk("err_len",    128'(err_len),        128'(err));
    endtask

    task automatic rand_cycle();
        int           nb, req, sz, en;
        logic         iv, dr, ordy, sr, rdy, ov, would, rok;
        logic [127:0] d, ed;
        iv   = 1'($urandom_range(0, 1));
        nb   = ($urandom_range(0, 39) == 0) ? 0 : int'($urandom_range(1, IB));
        dr   = ($urandom_range(0, 24) == 0);
        req  = int'($urandom_range(1, OB));
        ordy = ($urandom_range(0, 9) < 7);
        sr   = ($urandom_range(0, 299) == 0);
        d    = {$urandom(), $urandom(), $urandom(), $urandom()};
        drive(iv, nb, d, dr, req, ordy, sr);

        sz    = mq.size();
        rok   = (req >= 1) && (req <= OB);
        would = m_drn ? (sz != 0) : (sz >= req);
        rdy   = !m_drn && (FB - sz >= IB);
        ov    = would && rok;
        en    = !ov ? 0 : ((m_drn && sz < req) ? sz : req);
        ed    = '0;
        for (int k = 0; k < en; k++) ed[k*8 +: 8] = mq[k];

        #4;
        chk_all(rdy, ov, en, sz, ed, m_drn, m_err);
        @(posedge clk);
        #1;

        if (sr) begin
            mq.delete();
            m_drn = 0;
            m_err = 0;
        end else begin
            if (ov && ordy) repeat (en) void'(mq.pop_front());
            if (iv && rdy) begin
                if (nb >= 1 && nb <= IB) for (int k = 0; k < nb; k++) mq.push_back(d[k*8 +: 8]);
                else m_err = 1;
            end
            if (would && !rok) m_err = 1;
            if (!m_drn) begin
                if (dr && mq.size() != 0) m_drn = 1;
            end else if (mq.size() == 0) begin
                m_drn = 0;
            end
        end
    endtask

    initial begin
        // packing
        add(1,  5, 8'h01, 0, 16, 1, 0,  1, 0,  0,  0, 128'h0, 0, 0);
        add(1,  7, 8'h06, 0, 16, 1, 0,  1, 0,  0,  5, 128'h0, 0, 0);
        add(1,  4, 8'h0D, 0, 16, 1, 0,  1, 0,  0, 12, 128'h0, 0, 0);
        add(0,  1, 8'h00, 0, 16, 1, 0,  1, 1, 16, 16, 128'h100F0E0D0C0B0A090807060504030201, 0, 0);
        // simultaneous push 8 + pop 16
        add(1, 16, 8'h20, 0, 16, 0, 0,  1, 0,  0,  0, 128'h0, 0, 0);
        add(1,  8, 8'h40, 0, 16, 1, 0,  1, 1, 16, 16, 128'h2F2E2D2C2B2A29282726252423222120, 0, 0);
        add(0,  1, 8'h00, 0,  8, 0, 0,  1, 1,  8,  8, 128'h4746454443424140, 0, 0);
        add(0,  1, 8'h00, 0,  8, 1, 0,  1, 1,  8,  8, 128'h4746454443424140, 0, 0);
        // backpressure at level 17
        add(1, 16, 8'h50, 0, 16, 0, 0,  1, 0,  0,  0, 128'h0, 0, 0);
        add(1,  1, 8'h60, 0, 16, 0, 0,  1, 1, 16, 16, 128'h5F5E5D5C5B5A59585756555453525150, 0, 0);
        add(1,  4, 8'h70, 0, 16, 1, 0,  0, 1, 16, 17, 128'h5F5E5D5C5B5A59585756555453525150, 0, 0);
        add(0,  1, 8'h00, 0,  1, 0, 0,  1, 1,  1,  1, 128'h60, 0, 0);
        // drain 21 bytes as 16 + 5
        add(1,  4, 8'h90, 0, 16, 0, 0,  1, 0,  0,  1, 128'h0, 0, 0);
        add(1, 16, 8'h80, 0, 16, 0, 0,  1, 0,  0,  5, 128'h0, 0, 0);
        add(0,  1, 8'h00, 1, 16, 0, 0,  0, 1, 16, 21, 128'h8A898887868584838281809392919060, 0, 0);
        add(1,  4, 8'h70, 0, 16, 1, 0,  0, 1, 16, 21, 128'h8A898887868584838281809392919060, 1, 0);
        add(0,  1, 8'h00, 0, 16, 1, 0,  0, 1,  5,  5, 128'h8F8E8D8C8B, 1, 0);
        add(0,  1, 8'h00, 1, 16, 0, 0,  1, 0,  0,  0, 128'h0, 0, 0);
        // length error, sticky until sync_rst (which also beats a same-cycle push)
        add(1,  0, 8'h01, 0, 16, 0, 0,  1, 0,  0,  0, 128'h0, 0, 0);
        add(0,  1, 8'h00, 0, 16, 0, 0,  1, 0,  0,  0, 128'h0, 0, 1);
        add(1,  5, 8'h01, 0, 16, 0, 1,  1, 0,  0,  0, 128'h0, 0, 1);
        add(0,  1, 8'h00, 0, 16, 0, 0,  1, 0,  0,  0, 128'h0, 0, 0);

        drive(0, 1, '0, 0, 16, 0, 0);
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].iv, tbl[i].nb, mkdata(tbl[i].base), tbl[i].dr, tbl[i].req, tbl[i].ordy, tbl[i].sr);
            #4;
            chk_all(tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_n, tbl[i].e_lvl, tbl[i].e_data,
                    tbl[i].e_drn, tbl[i].e_err);
            @(posedge clk);
            #1;
        end

        // async reset mid-operation with level 20 and err set
        drive(1, 0, mkdata(8'h00), 0, 16, 0, 0);
        @(posedge clk); #1;
        drive(1, 16, mkdata(8'hA0), 0, 16, 0, 0);
        @(posedge clk); #1;
        drive(1, 4, mkdata(8'hB0), 0, 16, 0, 0);
        @(posedge clk); #1;
        drive(0, 1, '0, 0, 16, 0, 0);
        #1;
        chk("pre_rst_level", 128'(level), 128'(20));
        chk("pre_rst_err", 128'(err_len), 128'(1));
        chk("pre_rst_out_valid", 128'(bus.out_valid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_level", 128'(level), 128'(0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_err", 128'(err_len), 128'(0));
        chk("rst_out_nbytes", 128'(bus.out_nbytes), 128'(0));
        chk("rst_out_data", bus.out_data, 128'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        mq.delete();
        m_drn = 0;
        m_err = 0;
        for (int c = 0; c < 3000; c++) rand_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
